// File: rtl/vga_frame_reader_pkg.sv
// Shared VGA 640x480@60 timing constants, colour codes and small helpers
// for the framebuffer display reader.
package vga_frame_reader_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // 10-bit forms for direct comparison against the counters
    localparam logic [9:0] HVisEnd    = 10'(H_VISIBLE);
    localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0] VVisEnd    = 10'(V_VISIBLE);
    localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);

    typedef logic [2:0] rgb_t;

    // {R,G,B}, same encoding as the COLOR_* instruction operands
    localparam rgb_t COLOR_BLACK   = 3'b000;
    localparam rgb_t COLOR_BLUE    = 3'b001;
    localparam rgb_t COLOR_GREEN   = 3'b010;
    localparam rgb_t COLOR_CYAN    = 3'b011;
    localparam rgb_t COLOR_RED     = 3'b100;
    localparam rgb_t COLOR_MAGENTA = 3'b101;
    localparam rgb_t COLOR_YELLOW  = 3'b110;
    localparam rgb_t COLOR_WHITE   = 3'b111;

    function automatic logic in_range(logic [9:0] x, logic [9:0] lo, logic [9:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Framebuffer read port plus VGA pin bundle; master is the reader.
// iTestMode exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_frame_reader_if;

    logic [2:0]  iReadData;
    logic [16:0] oReadAddress;
    logic        oReadEnable;
    logic        oRed;
    logic        oGreen;
    logic        oBlue;
    logic        oHSync;
    logic        oVSync;
    logic        oFrameStart;
`ifdef VGA_TEST_PATTERN_EN
    logic        iTestMode;
`endif

    modport master (
        input  iReadData,
`ifdef VGA_TEST_PATTERN_EN
        input  iTestMode,
`endif
        output oReadAddress,
        output oReadEnable,
        output oRed,
        output oGreen,
        output oBlue,
        output oHSync,
        output oVSync,
        output oFrameStart
    );

    modport slave (
        output iReadData,
`ifdef VGA_TEST_PATTERN_EN
        output iTestMode,
`endif
        input  oReadAddress,
        input  oReadEnable,
        input  oRed,
        input  oGreen,
        input  oBlue,
        input  oHSync,
        input  oVSync,
        input  oFrameStart
    );

endinterface

// File: rtl/vga_sync_counter.sv
// 25 MHz pixel tick from the 50 MHz clock plus the 800x525 h/v scan counters
// and a one-clock frame start pulse.
module vga_sync_counter
    import vga_frame_reader_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       tick_o,
    output logic       frame_start_o
);

    logic       phase_q, phase_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        phase_d       = ~phase_q;
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;
        if (phase_q) begin
            if (h_q == HLast) begin
                h_d = '0;
                if (v_q == VLast) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase_q       <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign tick_o        = phase_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_frame_reader.sv
// Framebuffer-to-VGA reader: window address generation and 1-pixel output pipeline.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int unsigned FB_WIDTH     = 256,
    parameter int unsigned FB_HEIGHT    = 384,
    parameter int unsigned H_OFFSET     = 192,
    parameter int unsigned V_OFFSET     = 48,
    parameter logic [2:0]  BORDER_COLOR = 3'b000
) (
    input  logic                Clock,
    input  logic                Reset,
    vga_frame_reader_if.master  bus
);

    localparam logic [9:0] WinHStart = 10'(H_OFFSET);
    localparam logic [9:0] WinHEnd   = 10'(H_OFFSET + FB_WIDTH);
    localparam logic [9:0] WinVStart = 10'(V_OFFSET);
    localparam logic [9:0] WinVEnd   = 10'(V_OFFSET + FB_HEIGHT);

    logic [9:0] h, v;
    logic       tick;
    logic       frame_start;

    vga_sync_counter u_sync (
        .Clock         (Clock),
        .Reset         (Reset),
        .h_o           (h),
        .v_o           (v),
        .tick_o        (tick),
        .frame_start_o (frame_start)
    );

    logic       in_window;
    logic       visible;
    logic       read_en;
    logic [7:0] col;
    logic [8:0] row;
    rgb_t       pixel;

    logic [2:0] rgb_q, rgb_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    always_comb begin
        in_window = in_range(h, WinHStart, WinHEnd) && in_range(v, WinVStart, WinVEnd);
        visible   = (h < HVisEnd) && (v < VVisEnd);
        col       = 8'(h - WinHStart);
        row       = 9'(v - WinVStart);
`ifdef VGA_TEST_PATTERN_EN
        read_en   = in_window && !bus.iTestMode;
`else
        read_en   = in_window;
`endif
    end

    // Counters are stable across the 2-clock pixel, so RAM data for pixel h
    // is already on iReadData at the tick that registers pixel h.
    always_comb begin
        pixel = COLOR_BLACK;
        if (in_window) begin
`ifdef VGA_TEST_PATTERN_EN
            pixel = bus.iTestMode ? col[7:5] : bus.iReadData;
`else
            pixel = bus.iReadData;
`endif
        end else if (visible) begin
            pixel = BORDER_COLOR;
        end

        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (tick) begin
            rgb_d   = pixel;
            hsync_d = ~in_range(h, HSyncStart, HSyncEnd);
            vsync_d = ~in_range(v, VSyncStart, VSyncEnd);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rgb_q   <= 3'b000;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign bus.oReadEnable  = read_en;
    assign bus.oReadAddress = in_window ? {row, col} : 17'd0;
    assign bus.oRed         = rgb_q[2];
    assign bus.oGreen       = rgb_q[1];
    assign bus.oBlue        = rgb_q[0];
    assign bus.oHSync       = hsync_q;
    assign bus.oVSync       = vsync_q;
    assign bus.oFrameStart  = frame_start;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: random framebuffer contents, screen-position model
// derived from the elapsed pixel-tick count; also covers VGA_TEST_PATTERN_EN.
module tb_vga_frame_reader;

    localparam logic [2:0] BORDER = 3'b000;
    localparam int         FRAME_TICKS = 800 * 525;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    vga_frame_reader_if bus ();

    vga_frame_reader dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #10 Clock = ~Clock;

    // Synchronous-read RAM model; disabled cycles return junk on purpose
    logic [2:0] mem [0:131071];
    logic [2:0] rd_q;
    always @(posedge Clock) begin
        if (bus.oReadEnable === 1'b1) rd_q <= mem[bus.oReadAddress];
        else                          rd_q <= 3'($urandom);
    end
    assign bus.iReadData = rd_q;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n        = 0;
    int   hs_low   = 0;
    int   hs_first = -1;
    logic tm_cur   = 1'b0;
    logic tm_pix   = 1'b0;

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h n=%0d", tag, obs, exp, n);
        end
    endtask

    function automatic logic in_win(int h, int v);
        return h >= 192 && h < 448 && v >= 48 && v < 432;
    endfunction

    function automatic logic [2:0] pixel_colour(int h, int v, logic tm);
        if (in_win(h, v)) return tm ? 3'((h - 192) / 32) : mem[(v - 48) * 256 + (h - 192)];
        if (h < 640 && v < 480) return BORDER;
        return 3'b000;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_rgb"},   17'({bus.oRed, bus.oGreen, bus.oBlue}), 17'd0);
        check({tag, "_hsync"}, 17'(bus.oHSync), 17'd1);
        check({tag, "_vsync"}, 17'(bus.oVSync), 17'd1);
        check({tag, "_ren"},   17'(bus.oReadEnable), 17'd0);
        check({tag, "_raddr"}, bus.oReadAddress, 17'd0);
        check({tag, "_fs"},    17'(bus.oFrameStart), 17'd0);
    endtask

    // One clock: model position from tick count t = n/2 since reset release
    task automatic step();
        int         t, h, v, p, ph, pv;
        logic [2:0] e_rgb;
        logic       e_hs, e_vs, e_fs;
        logic [2:0] rgb;
        @(posedge Clock);
        n++;
        if (n % 2 == 0) tm_pix = tm_cur;
        @(negedge Clock);
        t = n / 2;
        h = t % 800;
        v = (t / 800) % 525;
        e_fs = (n % 2 == 0) && (t > 0) && (t % FRAME_TICKS == 0);
        if (t == 0) begin
            e_rgb = 3'b000; e_hs = 1'b1; e_vs = 1'b1;
        end else begin
            p  = t - 1;
            ph = p % 800;
            pv = (p / 800) % 525;
            e_hs  = !(ph >= 656 && ph < 752);
            e_vs  = !(pv >= 490 && pv < 492);
            e_rgb = pixel_colour(ph, pv, tm_pix);
        end
        rgb = {bus.oRed, bus.oGreen, bus.oBlue};
        check("rgb",   17'(rgb), 17'(e_rgb));
        check("hsync", 17'(bus.oHSync), 17'(e_hs));
        check("vsync", 17'(bus.oVSync), 17'(e_vs));
        check("ren",   17'(bus.oReadEnable), 17'(in_win(h, v) && !tm_cur));
        check("raddr", bus.oReadAddress,
              in_win(h, v) ? 17'((v - 48) * 256 + (h - 192)) : 17'd0);
        check("fstart", 17'(bus.oFrameStart), 17'(e_fs));
        if (t == 48 * 800 + 192) begin
            check("addr_first", bus.oReadAddress, 17'd0);
            check("ren_first",  17'(bus.oReadEnable), 17'd1);
        end
        if (t == 48 * 800 + 447) check("addr_lastcol", bus.oReadAddress, 17'd255);
        if (t == 48 * 800 + 448) check("ren_off_448", 17'(bus.oReadEnable), 17'd0);
        if (t == 48 * 800 + 198) check("data_110", 17'(rgb), 17'(3'b110));
        if (t == 48 * 800 + 101) check("border_h100", 17'(rgb), 17'(BORDER));
        if (t == 48 * 800 + 701) check("blank_h700", 17'(rgb), 17'd0);
        if (bus.oHSync === 1'b0) begin
            hs_low++;
            if (hs_first < 0) hs_first = n;
        end
`ifdef VGA_TEST_PATTERN_EN
        tm_cur = (v == 49);
        bus.iTestMode = tm_cur;
`endif
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 3'($urandom);
        mem[{9'd0, 8'd5}] = 3'b110;
`ifdef VGA_TEST_PATTERN_EN
        bus.iTestMode = 1'b0;
`endif
        // Reset held for 3 clocks
        repeat (3) begin
            @(posedge Clock);
            @(negedge Clock);
            check_reset_state("por");
        end
        Reset = 1'b0;

        // First ticks and a partial line, then a 1-clock reset mid-line
        while (n < 600) step();
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        check_reset_state("midreset");
        Reset    = 1'b0;
        n        = 0;
        tm_pix   = 1'b0;
        hs_low   = 0;
        hs_first = -1;

        // Two full lines: hsync width and position
        while (n < 3200) step();
        check("hsync_low_clocks_2lines", 17'(hs_low), 17'd384);
        check("hsync_first_low_clock", 17'(hs_first), 17'd1314);

        // Into the framebuffer window (rows 0 and 1)
        while (n < 2 * (49 * 800 + 500)) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
